washer_plant_model: RTL and testbench

- Synthesizable appliance-side model of the washing machine: the responder end of the controller's actuator/sensor interface.
- Consumes the six actuator outputs of Washing_Machine and produces WATER_LEVEL_SENSOR and TEMP_SENSOR as single-cycle event pulses, which is the form the controller expects.
- Tracks water level and water temperature with prescaled saturating counters, and latches plant-misuse faults.
- Used in closed-loop simulation and FPGA demo builds in place of the real drum.

---
 rtl/washer_pkg.sv | 21 ++
 rtl/plant_rate_counter.sv | 64 ++++++
 rtl/washer_plant_model.sv | 107 ++++++++++
 tb/tb_washer_plant_model.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared constants for the washing-machine plant model: fault bit positions
// and the default plant dynamics.
package washer_pkg;

  localparam int FLT_VALVE_PUMP   = 0;
  localparam int FLT_DRY_HEAT     = 1;
  localparam int FLT_UNLOCKED_RUN = 2;
  localparam int FLT_OVERFLOW     = 3;

  localparam int DEF_LEVEL_W        = 8;
  localparam int DEF_TEMP_W         = 8;
  localparam int DEF_FILL_DIV       = 4;
  localparam int DEF_DRAIN_DIV      = 2;
  localparam int DEF_HEAT_DIV       = 8;
  localparam int DEF_COOL_DIV       = 32;
  localparam int DEF_LEVEL_FULL     = 16;
  localparam int DEF_LEVEL_MIN_HEAT = 8;
  localparam int DEF_TEMP_AMBIENT   = 20;
  localparam int DEF_TEMP_TARGET    = 40;

endpackage

// File: rtl/plant_rate_counter.sv
// Prescaled up/down saturating counter: one step per DIV_UP cycles of inc,
// or per DIV_DN cycles of dec. Asserting both (or neither) holds the value.
module plant_rate_counter #(
  parameter int W         = 8,
  parameter int DIV_UP    = 4,
  parameter int DIV_DN    = 2,
  parameter int MIN       = 0,
  parameter int MAX       = 255,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam int DIV_MAX = (DIV_UP > DIV_DN) ? DIV_UP : DIV_DN;
  localparam int PW      = $clog2(DIV_MAX + 1);

  logic [PW-1:0] up_pre_q, up_pre_d;
  logic [PW-1:0] dn_pre_q, dn_pre_d;
  logic [W-1:0]  value_q, value_d;
  logic          up_en, dn_en;

  always_comb begin
    up_en    = inc && !dec;
    dn_en    = dec && !inc;
    up_pre_d = '0;
    dn_pre_d = '0;
    value_d  = value_q;
    // A prescaler restarts from zero whenever its direction is not active,
    // so the first step always lands exactly DIV cycles after assertion.
    if (up_en) begin
      if (up_pre_q == PW'(DIV_UP - 1)) begin
        if (value_q < W'(MAX)) value_d = value_q + 1'b1;
      end else begin
        up_pre_d = up_pre_q + 1'b1;
      end
    end
    if (dn_en) begin
      if (dn_pre_q == PW'(DIV_DN - 1)) begin
        if (value_q > W'(MIN)) value_d = value_q - 1'b1;
      end else begin
        dn_pre_d = dn_pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pre_q <= '0;
      dn_pre_q <= '0;
      value_q  <= W'(RESET_VAL);
    end else begin
      up_pre_q <= up_pre_d;
      dn_pre_q <= dn_pre_d;
      value_q  <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/washer_plant_model.sv
// Appliance-side model of the washing machine: turns actuator commands into
// level/temperature dynamics, one-shot sensor pulses and sticky misuse faults.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int LEVEL_W        = DEF_LEVEL_W,
  parameter int TEMP_W         = DEF_TEMP_W,
  parameter int FILL_DIV       = DEF_FILL_DIV,
  parameter int DRAIN_DIV      = DEF_DRAIN_DIV,
  parameter int HEAT_DIV       = DEF_HEAT_DIV,
  parameter int COOL_DIV       = DEF_COOL_DIV,
  parameter int LEVEL_FULL     = DEF_LEVEL_FULL,
  parameter int LEVEL_MIN_HEAT = DEF_LEVEL_MIN_HEAT,
  parameter int TEMP_AMBIENT   = DEF_TEMP_AMBIENT,
  parameter int TEMP_TARGET    = DEF_TEMP_TARGET
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               DOOR_LOCK,
  input  logic               WATER_VALVE,
  input  logic               DETERGENT_HATCH,
  input  logic               WATER_HEATER,
  input  logic               DRUM_MOTOR,
  input  logic               WATER_PUMP,
  output logic               WATER_LEVEL_SENSOR,
  output logic               TEMP_SENSOR,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic [TEMP_W-1:0]  TEMP,
  output logic [3:0]         FAULT
);

  logic [LEVEL_W-1:0] level;
  logic [TEMP_W-1:0]  temp;
  logic               heat_en, cool_en;
  logic               level_hi, temp_hi;
  logic               wls_q, wls_d, wls_arm_q, wls_arm_d;
  logic               ts_q, ts_d, ts_arm_q, ts_arm_d;
  logic [3:0]         fault_q, fault_d;
  logic               hatch_unused;

  // The hatch has no physical effect on the plant; it is only observed.
  assign hatch_unused = DETERGENT_HATCH;

  plant_rate_counter #(
    .W(LEVEL_W), .DIV_UP(FILL_DIV), .DIV_DN(DRAIN_DIV),
    .MIN(0), .MAX((1 << LEVEL_W) - 1), .RESET_VAL(0)
  ) u_level (
    .clk(clk), .rst_n(rst_n),
    .inc(WATER_VALVE), .dec(WATER_PUMP),
    .value(level)
  );

  // Heating only works with enough water; cooling stops at ambient.
  assign heat_en = WATER_HEATER && (level >= LEVEL_W'(LEVEL_MIN_HEAT));
  assign cool_en = !WATER_HEATER && (temp > TEMP_W'(TEMP_AMBIENT));

  plant_rate_counter #(
    .W(TEMP_W), .DIV_UP(HEAT_DIV), .DIV_DN(COOL_DIV),
    .MIN(TEMP_AMBIENT), .MAX((1 << TEMP_W) - 1), .RESET_VAL(TEMP_AMBIENT)
  ) u_temp (
    .clk(clk), .rst_n(rst_n),
    .inc(heat_en), .dec(cool_en),
    .value(temp)
  );

  always_comb begin
    level_hi  = level >= LEVEL_W'(LEVEL_FULL);
    temp_hi   = temp >= TEMP_W'(TEMP_TARGET);
    wls_d     = wls_arm_q && level_hi;
    ts_d      = ts_arm_q && temp_hi;
    wls_arm_d = wls_arm_q;
    ts_arm_d  = ts_arm_q;
    if (wls_d) wls_arm_d = 1'b0;
    else if (!level_hi) wls_arm_d = 1'b1;
    if (ts_d) ts_arm_d = 1'b0;
    else if (!temp_hi) ts_arm_d = 1'b1;

    fault_d = fault_q;
    if (WATER_VALVE && WATER_PUMP) fault_d[FLT_VALVE_PUMP] = 1'b1;
    if (WATER_HEATER && (level < LEVEL_W'(LEVEL_MIN_HEAT))) fault_d[FLT_DRY_HEAT] = 1'b1;
    if ((DRUM_MOTOR || WATER_VALVE) && !DOOR_LOCK) fault_d[FLT_UNLOCKED_RUN] = 1'b1;
    if (WATER_VALVE && (level == {LEVEL_W{1'b1}})) fault_d[FLT_OVERFLOW] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wls_q     <= 1'b0;
      wls_arm_q <= 1'b1;
      ts_q      <= 1'b0;
      ts_arm_q  <= 1'b1;
      fault_q   <= '0;
    end else begin
      wls_q     <= wls_d;
      wls_arm_q <= wls_arm_d;
      ts_q      <= ts_d;
      ts_arm_q  <= ts_arm_d;
      fault_q   <= fault_d;
    end
  end

  assign WATER_LEVEL_SENSOR = wls_q;
  assign TEMP_SENSOR        = ts_q;
  assign LEVEL              = level;
  assign TEMP               = temp;
  assign FAULT              = fault_q;

endmodule

// File: tb/tb_washer_plant_model.sv
// Directed bench for washer_plant_model: a table of actuator settings held for
// a number of cycles with hand-computed outputs, plus an async-reset sequence.
module tb_washer_plant_model;
  import washer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       door_lock = 1'b0, water_valve = 1'b0, detergent_hatch = 1'b0;
  logic       water_heater = 1'b0, drum_motor = 1'b0, water_pump = 1'b0;
  logic       wls, ts;
  logic [7:0] level, temp;
  logic [3:0] fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         lock, valve, heater, motor, pump;
    int         ncyc;
    int         lvl, tmp;
    bit         wls, ts;
    logic [3:0] flt;
  } vec_t;

  vec_t vecs[27];

  washer_plant_model dut (
    .clk(clk), .rst_n(rst_n),
    .DOOR_LOCK(door_lock), .WATER_VALVE(water_valve),
    .DETERGENT_HATCH(detergent_hatch), .WATER_HEATER(water_heater),
    .DRUM_MOTOR(drum_motor), .WATER_PUMP(water_pump),
    .WATER_LEVEL_SENSOR(wls), .TEMP_SENSOR(ts),
    .LEVEL(level), .TEMP(temp), .FAULT(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit lk, bit vl, bit ht, bit mo, bit pu, int n,
                              int l, int t, bit w, bit s, logic [3:0] f);
    vec_t v;
    v.lock = lk; v.valve = vl; v.heater = ht; v.motor = mo; v.pump = pu;
    v.ncyc = n; v.lvl = l; v.tmp = t; v.wls = w; v.ts = s; v.flt = f;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit lk, input bit vl, input bit ht, input bit mo, input bit pu);
    door_lock = lk; water_valve = vl; water_heater = ht; drum_motor = mo; water_pump = pu;
  endtask

  initial begin
    //               lk vl ht mo pu  ncyc  lvl  tmp  w  s  flt
    vecs[0]  = mk(0, 0, 0, 0, 0,    0,   0,  20, 0, 0, 4'h0);
    vecs[1]  = mk(1, 1, 0, 0, 0,   63,  15,  20, 0, 0, 4'h0);
    vecs[2]  = mk(1, 1, 0, 0, 0,    1,  16,  20, 0, 0, 4'h0);
    vecs[3]  = mk(1, 1, 0, 0, 0,    1,  16,  20, 1, 0, 4'h0);
    vecs[4]  = mk(1, 1, 0, 0, 0,    1,  16,  20, 0, 0, 4'h0);
    vecs[5]  = mk(1, 1, 0, 0, 0,    6,  18,  20, 0, 0, 4'h0);
    vecs[6]  = mk(1, 0, 1, 0, 0,  159,  18,  39, 0, 0, 4'h0);
    vecs[7]  = mk(1, 0, 1, 0, 0,    1,  18,  40, 0, 0, 4'h0);
    vecs[8]  = mk(1, 0, 1, 0, 0,    1,  18,  40, 0, 1, 4'h0);
    vecs[9]  = mk(1, 0, 1, 0, 0,    1,  18,  40, 0, 0, 4'h0);
    vecs[10] = mk(1, 0, 0, 0, 0,   31,  18,  40, 0, 0, 4'h0);
    vecs[11] = mk(1, 0, 0, 0, 0,    1,  18,  39, 0, 0, 4'h0);
    vecs[12] = mk(1, 0, 1, 0, 0,    8,  18,  40, 0, 0, 4'h0);
    vecs[13] = mk(1, 0, 1, 0, 0,    1,  18,  40, 0, 1, 4'h0);
    vecs[14] = mk(1, 0, 1, 0, 0,    1,  18,  40, 0, 0, 4'h0);
    vecs[15] = mk(1, 0, 0, 0, 1,   36,   0,  39, 0, 0, 4'h0);
    vecs[16] = mk(1, 0, 0, 0, 1,   10,   0,  39, 0, 0, 4'h0);
    vecs[17] = mk(1, 1, 0, 0, 0,   64,  16,  37, 0, 0, 4'h0);
    vecs[18] = mk(1, 1, 0, 0, 0,    1,  16,  37, 1, 0, 4'h0);
    vecs[19] = mk(1, 1, 0, 0, 1,    5,  16,  37, 0, 0, 4'h1);
    vecs[20] = mk(1, 0, 0, 0, 1,   32,   0,  36, 0, 0, 4'h1);
    vecs[21] = mk(1, 0, 1, 0, 0,   10,   0,  36, 0, 0, 4'h3);
    vecs[22] = mk(0, 0, 0, 1, 0,    1,   0,  36, 0, 0, 4'h7);
    vecs[23] = mk(0, 0, 0, 0, 0,    5,   0,  36, 0, 0, 4'h7);
    vecs[24] = mk(1, 1, 0, 0, 0, 1020, 255,  20, 0, 0, 4'h7);
    vecs[25] = mk(1, 1, 0, 0, 0,    1, 255,  20, 0, 0, 4'hF);
    vecs[26] = mk(1, 1, 0, 0, 0,    8, 255,  20, 0, 0, 4'hF);

    adv(2);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].lock, vecs[i].valve, vecs[i].heater, vecs[i].motor, vecs[i].pump);
      detergent_hatch = (i % 3 == 0);
      adv(vecs[i].ncyc);
      $display("[TB] vec %0d: L=%0d T=%0d WLS=%0b TS=%0b F=%h", i, level, temp, wls, ts, fault);
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
      check($sformatf("vec%0d_temp", i),  int'(temp),  vecs[i].tmp);
      check($sformatf("vec%0d_wls", i),   int'(wls),   int'(vecs[i].wls));
      check($sformatf("vec%0d_ts", i),    int'(ts),    int'(vecs[i].ts));
      check($sformatf("vec%0d_fault", i), int'(fault), int'(vecs[i].flt));
    end

    // Build up LEVEL=9, TEMP=30 mid-fill, then pulse rst_n low between edges.
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    adv(1);
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 0); adv(64);
    check("prep_fill_level", int'(level), 16);
    drive(1, 0, 1, 0, 0); adv(80);
    check("prep_heat_temp", int'(temp), 30);
    drive(1, 0, 0, 0, 1); adv(14);
    drive(1, 1, 0, 0, 1); adv(1);
    drive(1, 1, 0, 0, 0); adv(2);
    $display("[TB] pre-reset: L=%0d T=%0d F=%h", level, temp, fault);
    check("prep_level", int'(level), 9);
    check("prep_temp",  int'(temp),  30);
    check("prep_fault", int'(fault), 1);

    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset: L=%0d T=%0d F=%h", level, temp, fault);
    check("arst_level", int'(level), 0);
    check("arst_temp",  int'(temp),  20);
    check("arst_fault", int'(fault), 0);
    check("arst_wls",   int'(wls),   0);
    check("arst_ts",    int'(ts),    0);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_hold_level", int'(level), 0);
    adv(3);
    check("refill_3cyc_level", int'(level), 0);
    adv(1);
    $display("[TB] refill after reset: L=%0d", level);
    check("refill_4cyc_level", int'(level), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
